mem_arbiter: RTL

Shares the single memory port between the instruction-fetch path and the data load/store path. It arbitrates round-robin, allows one outstanding transaction at a time, and sequences the fixed memory read latency. It returns read data to the requester that issued the read. It sits between the fetch and memory stages on one side and the memory instance on the other.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// The arbiter takes the slave view; the surrounding environment (requesters
// plus memory instance) takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  // Data load/store port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  // Memory port
  logic          m_ren;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output m_ren, m_wen, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_ren, m_wen, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data load/store. One transaction in flight at a time; reads wait a fixed
// MEM_LAT cycles and the returned word is steered back to the issuing port.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } port_t;

  state_t           state;
  port_t            last_gnt;
  port_t            owner;
  logic [CNT_W-1:0] cnt;

  logic             gnt_if;
  logic             gnt_d;
  logic             d_write;
  logic [AW-1:0]    issue_addr;
  logic [DW-1:0]    issue_wdata;

  logic             if_rvalid_q;
  logic             d_rvalid_q;
  logic [DW-1:0]    if_rdata_q;
  logic [DW-1:0]    d_rdata_q;

  // Same-cycle grant: only in IDLE and never while reset is asserted; on a
  // tie the port that did not win last time gets the memory.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.if_req && (!bus.d_req || last_gnt == OWN_D)) begin
        gnt_if = 1'b1;
      end else if (bus.d_req) begin
        gnt_d = 1'b1;
      end
    end
  end

  // Drive the memory port from whichever requester was granted this cycle.
  always_comb begin
    d_write     = gnt_d && bus.d_we;
    issue_addr  = '0;
    issue_wdata = '0;
    if (gnt_if) begin
      issue_addr = bus.if_addr;
    end else if (gnt_d) begin
      issue_addr = bus.d_addr;
    end
    if (d_write) begin
      issue_wdata = bus.d_wdata;
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.m_ren     = gnt_if || (gnt_d && !bus.d_we);
  assign bus.m_wen     = d_write;
  assign bus.m_addr    = issue_addr;
  assign bus.m_wdata   = issue_wdata;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

  // Control FSM: records grant history and read ownership, counts down the
  // memory latency and captures the returned word into the owner's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= OWN_D;
      owner       <= OWN_IF;
      cnt         <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_if) begin
            last_gnt <= OWN_IF;
            owner    <= OWN_IF;
            cnt      <= LAT_LOAD;
            state    <= RD_WAIT;
          end else if (gnt_d) begin
            last_gnt <= OWN_D;
            // Writes finish at the grant edge; only reads occupy the port.
            if (!bus.d_we) begin
              owner <= OWN_D;
              cnt   <= LAT_LOAD;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // cnt reaches 1 in the cycle the memory presents the read word.
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (owner == OWN_IF) begin
              if_rdata_q  <= bus.m_rdata;
              if_rvalid_q <= 1'b1;
            end else begin
              d_rdata_q  <= bus.m_rdata;
              d_rvalid_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
